// File: rtl/segment_display_arbiter.sv
// segment_display_arbiter
//   Round-robin time-slice arbiter that shares one 8-digit seven-segment
//   display among N_SRC requesters. The current owner's 32-bit value is
//   registered onto numb. Every owner keeps the display for at least
//   HOLD_CYCLES cycles unless it withdraws its request first.
//   Optional build macro: SEG_ARB_PREEMPT_EN gives source 0 preemptive
//   priority over any other owner.
module segment_display_arbiter #(
   parameter int N_SRC       = 4,
   parameter int HOLD_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_SRC-1:0]     req,
   input  logic [32*N_SRC-1:0]  data,
   output logic [N_SRC-1:0]     grant,
   output logic [2:0]           owner_idx,
   output logic [31:0]          numb,
   output logic                 busy
);

   localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int CNT_W = $clog2(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_SRC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_OPEN
   } state_t;

   state_t           state, nxt_state;
   logic [CNT_W-1:0] count, nxt_count;
   logic [IDX_W-1:0] ptr, nxt_ptr;
   logic [IDX_W-1:0] owner, nxt_owner;
   logic [31:0]      nxt_numb;
   logic [N_SRC-1:0] others;

   // First set bit of mask, searching upward from base+1 and wrapping.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_SRC-1:0] mask,
                                                input logic [IDX_W-1:0] base);
      logic [IDX_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= N_SRC; k++) begin
         idx = (int'(base) + k) % N_SRC;
         if (!found && mask[idx]) begin
            pick  = IDX_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // State register: FSM, hold counter, round-robin pointer, owner, numb.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         count <= '0;
         ptr   <= PTR_RST;
         owner <= '0;
         numb  <= '0;
      end else begin
         state <= nxt_state;
         count <= nxt_count;
         ptr   <= nxt_ptr;
         owner <= nxt_owner;
         numb  <= nxt_numb;
      end
   end

   // Next-state logic: grant, hold timing, release, handoff (and preemption).
   always_comb begin
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      nxt_state = state;
      nxt_count = count;
      nxt_ptr   = ptr;
      nxt_owner = owner;
      others    = req & ~(N_SRC'(1) << owner);

      case (state)
         ST_IDLE: begin
            if (|req) begin
               nxt_owner = rr_pick(req, ptr);
               nxt_state = ST_HOLD;
               nxt_count = '0;
            end
         end
         default: begin
            if (!req[owner]) begin
               // Release: remember the leaver and re-arbitrate in the same cycle.
               nxt_ptr = owner;
               if (|others) begin
                  nxt_owner = rr_pick(others, owner);
                  nxt_state = ST_HOLD;
               end else begin
                  nxt_owner = '0;
                  nxt_state = ST_IDLE;
               end
               nxt_count = '0;
            end
`ifdef SEG_ARB_PREEMPT_EN
            else if (req[0] && owner != '0) begin
               // Preemption by source 0; the pointer is left untouched.
               nxt_owner = '0;
               nxt_state = ST_HOLD;
               nxt_count = '0;
            end
`endif
            else if (state == ST_HOLD) begin
               if (count == CNT_LAST) begin
                  nxt_state = ST_OPEN;
               end else begin
                  nxt_count = count + 1'b1;
               end
            end else if (|others) begin
               // Open slot with competition: hand off to the next in line.
               nxt_owner = rr_pick(others, owner);
               nxt_state = ST_HOLD;
               nxt_count = '0;
            end
         end
      endcase
   end

   // Output decode: grant/busy/owner_idx from state, numb mux for next owner.
   always_comb begin
      busy      = (state != ST_IDLE);
      grant     = busy ? (N_SRC'(1) << owner) : '0;
      owner_idx = 3'(owner);
      nxt_numb  = '0;
      if (nxt_state != ST_IDLE) begin
         nxt_numb = data[32*int'(nxt_owner) +: 32];
      end
   end

endmodule

// File: tb/tb_segment_display_arbiter.sv
// tb_segment_display_arbiter
//   Directed scenarios plus randomized traffic for segment_display_arbiter
//   (N_SRC=4, HOLD_CYCLES=8). Expected values come from a behavioural model
//   that tracks the owner and how long it has held the display.
//   Honours SEG_ARB_PREEMPT_EN when the bench is built with it.
module tb_segment_display_arbiter;

   localparam int N    = 4;
   localparam int HOLD = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [32*N-1:0] data;
   logic [N-1:0]  grant;
   logic [2:0]    owner_idx;
   logic [31:0]   numb;
   logic          busy;

   int checks = 0;
   int errors = 0;

   // Model: owner (-1 idle), cycles already held, last released owner.
   int          m_owner;
   int          m_age;
   int          m_ptr;
   logic [31:0] m_numb;

   segment_display_arbiter #(.N_SRC(N), .HOLD_CYCLES(HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data      (data),
      .grant     (grant),
      .owner_idx (owner_idx),
      .numb      (numb),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [N-1:0] mask, input int base);
      for (int k = 1; k <= N; k++) begin
         if (mask[(base + k) % N]) return (base + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_grant();
      logic [N-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   // One clock: advance the model on the inputs sampled at this edge,
   // leaving time at posedge+1 for the caller to compare and re-drive.
   task automatic tick();
      logic [N-1:0] rest;
      @(posedge clk);
      #1;
      if (rst) begin
         m_owner = -1; m_age = 0; m_ptr = N - 1;
      end else if (m_owner < 0) begin
         if (req != '0) begin m_owner = pick(req, m_ptr); m_age = 0; end
      end else if (!req[m_owner]) begin
         m_ptr = m_owner;
         m_owner = pick(req, m_ptr);
         m_age = 0;
      end else begin
         rest = req;
         rest[m_owner] = 1'b0;
`ifdef SEG_ARB_PREEMPT_EN
         if (req[0] && m_owner != 0) begin
            m_owner = 0; m_age = 0;
         end else
`endif
         if (m_age >= HOLD && rest != '0) begin
            m_owner = pick(rest, m_owner); m_age = 0;
         end else if (m_age < 1000) begin
            m_age++;
         end
      end
      m_numb = (m_owner < 0) ? 32'h0 : data[32*m_owner +: 32];
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0;
      data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         data = {$urandom, $urandom, $urandom, $urandom};
         tick();
         checks++;
         if (grant !== 4'b0000 || busy !== 1'b0 || numb !== 32'h0 || owner_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got grant=%b busy=%b numb=%h idx=%0d exp 0/0/0/0",
                     c, grant, busy, numb, owner_idx);
         end
      end
   endtask

   task automatic test_single();
      logic [31:0] v;
      do_reset();
      data[95:64] = 32'hDEADBEEF;
      req = 4'b0100;
      tick();
      checks++;
      if (grant !== 4'b0100 || owner_idx !== 3'd2 || numb !== 32'hDEADBEEF || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_grant got grant=%b idx=%0d numb=%h busy=%b exp 0100/2/deadbeef/1",
                  grant, owner_idx, numb, busy);
      end
      for (int c = 0; c < 20; c++) begin
         v = $urandom;
         data[95:64] = v;
         tick();
         checks++;
         if (grant !== 4'b0100 || numb !== v) begin
            errors++;
            $display("FAIL single_hold cyc=%0d got grant=%b numb=%h exp 0100/%h", c, grant, numb, v);
         end
      end
   endtask

   // Owner holds HOLD cycles counting up, then one open cycle decides the handoff.
   task automatic hold_and_move(input string name, input logic [N-1:0] from, input logic [N-1:0] to);
      int held;
      held = 1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (grant !== from) break;
         held++;
      end
      checks++;
      if (grant !== to || held != HOLD + 1) begin
         errors++;
         $display("FAIL %s got grant=%b held=%0d exp %b held=%0d", name, grant, held, to, HOLD + 1);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      req = 4'b0011;
      tick();
      checks++;
      if (grant !== 4'b0001) begin
         errors++;
         $display("FAIL rr_first got %b exp 0001", grant);
      end
      hold_and_move("rr_0_to_1", 4'b0001, 4'b0010);
      hold_and_move("rr_1_to_0", 4'b0010, 4'b0001);
   endtask

   task automatic test_release();
      do_reset();
      req = 4'b0010;
      tick();
      for (int c = 0; c < 3; c++) tick();
      req = 4'b1000;
      tick();
      checks++;
      if (grant !== 4'b1000 || busy !== 1'b1 || owner_idx !== 3'd3) begin
         errors++;
         $display("FAIL release_handoff got grant=%b busy=%b idx=%0d exp 1000/1/3", grant, busy, owner_idx);
      end
      req = 4'b1001;
      hold_and_move("release_restart", 4'b1000, 4'b0001);
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b0010;
      tick();
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if (grant !== 4'b0000 || numb !== 32'h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got grant=%b numb=%h busy=%b exp 0000/0/0", grant, numb, busy);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (grant !== 4'b0010) begin
         errors++;
         $display("FAIL reset_regrant got %b exp 0010", grant);
      end
   endtask

   task automatic test_preempt();
      logic [31:0] d0;
      do_reset();
      req = 4'b0100;
      tick();
      tick();
      tick();
      d0 = $urandom;
      data[31:0] = d0;
      req = 4'b0101;
      tick();
`ifdef SEG_ARB_PREEMPT_EN
      checks++;
      if (grant !== 4'b0001 || numb !== d0) begin
         errors++;
         $display("FAIL preempt got grant=%b numb=%h exp 0001/%h", grant, numb, d0);
      end
`else
      checks++;
      if (grant !== 4'b0100) begin
         errors++;
         $display("FAIL no_preempt got %b exp 0100", grant);
      end
      begin
         int held;
         held = 4;
         for (int c = 0; c < 40; c++) begin
            tick();
            if (grant !== 4'b0100) break;
            held++;
         end
         checks++;
         if (grant !== 4'b0001 || held != HOLD + 1) begin
            errors++;
            $display("FAIL no_preempt_open got grant=%b held=%0d exp 0001 held=%0d", grant, held, HOLD + 1);
         end
      end
`endif
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(15) == 0) req[i] = ~req[i];
         end
         data = {$urandom, $urandom, $urandom, $urandom};
         rst  = ($urandom_range(299) == 0);
         tick();
         checks++;
         if (grant !== exp_grant() || busy !== (m_owner >= 0) || numb !== m_numb ||
             owner_idx !== 3'((m_owner < 0) ? 0 : m_owner)) begin
            errors++;
            $display("FAIL random cyc=%0d got grant=%b busy=%b idx=%0d numb=%h exp grant=%b owner=%0d numb=%h",
                     c, grant, busy, owner_idx, numb, exp_grant(), m_owner, m_numb);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = '0; data = '0;
      m_owner = -1; m_age = 0; m_ptr = N - 1; m_numb = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_release();
      test_reset_mid();
      test_preempt();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
